// File: rtl/aes_block_ctrl_if.sv
// Handshake and core-control bundle for aes_block_ctrl.
// master is the controller's view; slave is the frame source / AES core / result sink side.
interface aes_block_ctrl_if;
   logic         rx_valid;
   logic [391:0] rx_frame;
   logic         rx_ready;
   logic         core_start;
   logic         core_mode;
   logic [1:0]   core_klen;
   logic [127:0] core_data;
   logic [255:0] core_key;
   logic         core_done;
   logic [127:0] core_result;
   logic         tx_valid;
   logic [127:0] tx_data;
   logic [1:0]   tx_status;
   logic         tx_ready;
   logic         busy;
   logic [7:0]   err_count;

   modport master (
      input  rx_valid, rx_frame, core_done, core_result, tx_ready,
      output rx_ready, core_start, core_mode, core_klen, core_data, core_key,
             tx_valid, tx_data, tx_status, busy, err_count
   );

   modport slave (
      output rx_valid, rx_frame, core_done, core_result, tx_ready,
      input  rx_ready, core_start, core_mode, core_klen, core_data, core_key,
             tx_valid, tx_data, tx_status, busy, err_count
   );
endinterface

// File: rtl/aes_block_ctrl.sv
// AES block controller: accepts key/data frames, sequences one core operation at a time
// with a done watchdog, and queues {status, result} entries in a first-word-fall-through FIFO.
module aes_block_ctrl #(
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 1023
) (
   input logic              clk,
   input logic              reset,
   aes_block_ctrl_if.master bus
);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int WD_W  = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
   localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, WAIT, PUSH} state_t;

   state_t             r_state, w_next;
   logic [127:0]       r_data, r_result;
   logic [255:0]       r_key;
   logic               r_mode;
   logic [1:0]         r_klen, r_status;
   logic [WD_W-1:0]    r_wdog;
   logic [129:0]       r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   r_wptr, r_rptr;
   logic [CNT_W-1:0]   r_count;
   logic [7:0]         r_err;

   logic               w_accept, w_klen_ok, w_push, w_pop, w_empty, w_timeout;
   logic [1:0]         w_klen;
   logic [6:0]         w_kbytes;

   assign w_kbytes = bus.rx_frame[262:256];

   always_comb begin
      w_klen_ok = 1'b1;
      w_klen    = 2'd0;
      case (w_kbytes)
         7'd16:   w_klen = 2'd0;
         7'd24:   w_klen = 2'd1;
         7'd32:   w_klen = 2'd2;
         default: w_klen_ok = 1'b0;
      endcase
   end

   assign w_empty      = (r_count == '0);
   assign bus.rx_ready = (r_state == IDLE) && (r_count < CNT_FULL);
   assign w_accept     = bus.rx_valid && bus.rx_ready;
   // Done wins over the watchdog when both land on the same cycle.
   assign w_timeout    = !bus.core_done && (r_wdog == WD_LAST);
   assign w_push       = (r_state == PUSH);
   assign w_pop        = bus.tx_valid && bus.tx_ready;

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_next = w_klen_ok ? START : PUSH;
         START:   w_next = WAIT;
         WAIT:    if (bus.core_done || w_timeout) w_next = PUSH;
         PUSH:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_data   <= '0;
         r_key    <= '0;
         r_mode   <= 1'b0;
         r_klen   <= 2'd0;
         r_status <= 2'b00;
         r_result <= '0;
         r_wdog   <= '0;
      end else begin
         case (r_state)
            IDLE: if (w_accept) begin
               r_data   <= bus.rx_frame[391:264];
               r_key    <= bus.rx_frame[255:0];
               r_mode   <= bus.rx_frame[263];
               r_klen   <= w_klen;
               r_status <= w_klen_ok ? 2'b00 : 2'b01;
               r_result <= '0;
            end
            START: r_wdog <= '0;
            WAIT: begin
               if (bus.core_done) begin
                  r_result <= bus.core_result;
                  r_status <= 2'b00;
               end else if (w_timeout) begin
                  r_result <= '0;
                  r_status <= 2'b10;
                  r_wdog   <= WD_LIMIT;
               end else begin
                  r_wdog <= r_wdog + WD_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Entry storage carries no reset; emptiness is tracked by r_count alone.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= {r_status, r_result};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_err   <= 8'd0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PTR_W'(1);
         if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: ;
         endcase
         if (w_push && (r_status != 2'b00) && (r_err != 8'hFF)) r_err <= r_err + 8'd1;
      end
   end

   assign bus.tx_valid   = !w_empty;
   assign bus.tx_data    = w_empty ? '0 : r_mem[r_rptr][127:0];
   assign bus.tx_status  = w_empty ? 2'b00 : r_mem[r_rptr][129:128];
   assign bus.core_start = (r_state == START);
   assign bus.core_mode  = r_mode;
   assign bus.core_klen  = r_klen;
   assign bus.core_data  = r_data;
   assign bus.core_key   = r_key;
   assign bus.busy       = (r_state != IDLE);
   assign bus.err_count  = r_err;
endmodule

// File: tb/tb_aes_block_ctrl.sv
// Directed bench for aes_block_ctrl: hand-computed expectations per scenario task.
module tb_aes_block_ctrl;
   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;

   localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [255:0] KEY256 =
      256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

   aes_block_ctrl_if bus();
   aes_block_ctrl_if bus2();

   aes_block_ctrl #(.FIFO_DEPTH(4), .TIMEOUT(1023)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );
   aes_block_ctrl #(.FIFO_DEPTH(4), .TIMEOUT(8)) dut_to (
      .clk(clk), .reset(reset), .bus(bus2)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [391:0] mk(input logic [127:0] d, input logic [7:0] c,
                                       input logic [255:0] k);
      return {d, c, k};
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
      n_cmp++; if (bus.rx_ready !== 1'b1) begin n_err++; $display("FAIL rst_rx_ready: got %b want 1", bus.rx_ready); end
      n_cmp++; if (bus.core_start !== 1'b0) begin n_err++; $display("FAIL rst_core_start: got %b want 0", bus.core_start); end
      n_cmp++; if (bus.tx_valid !== 1'b0) begin n_err++; $display("FAIL rst_tx_valid: got %b want 0", bus.tx_valid); end
      n_cmp++; if ({bus.tx_status, bus.tx_data} !== 130'h0) begin n_err++; $display("FAIL rst_tx: got %h want 0", {bus.tx_status, bus.tx_data}); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
      n_cmp++; if (bus.err_count !== 8'd0) begin n_err++; $display("FAIL rst_err: got %0d want 0", bus.err_count); end
      n_cmp++; if ({bus.core_mode, bus.core_klen, bus.core_data, bus.core_key} !== 387'h0) begin
         n_err++; $display("FAIL rst_core_regs: got nonzero want 0"); end
   endtask

   task automatic test_enc128();
      // core_done in IDLE must be ignored
      bus.core_done = 1'b1; bus.core_result = 128'hdead;
      tick();
      bus.core_done = 1'b0;
      tick();
      n_cmp++; if (bus.tx_valid !== 1'b0) begin n_err++; $display("FAIL idle_done_ignored: got %b want 0", bus.tx_valid); end
      bus.rx_frame = mk(PT, 8'h10, KEY128);
      bus.rx_valid = 1'b1;
      tick();
      bus.rx_valid = 1'b0;
      n_cmp++; if (bus.core_start !== 1'b1) begin n_err++; $display("FAIL enc_start: got %b want 1", bus.core_start); end
      n_cmp++; if ({bus.core_mode, bus.core_klen} !== 3'b000) begin n_err++; $display("FAIL enc_mode_klen: got %b want 000", {bus.core_mode, bus.core_klen}); end
      n_cmp++; if (bus.core_data !== PT) begin n_err++; $display("FAIL enc_data: got %h want %h", bus.core_data, PT); end
      n_cmp++; if (bus.core_key !== KEY128) begin n_err++; $display("FAIL enc_key: got %h want %h", bus.core_key, KEY128); end
      n_cmp++; if ({bus.rx_ready, bus.busy} !== 2'b01) begin n_err++; $display("FAIL enc_rdy_busy: got %b want 01", {bus.rx_ready, bus.busy}); end
      tick();
      n_cmp++; if (bus.core_start !== 1'b0) begin n_err++; $display("FAIL enc_start_pulse: got %b want 0", bus.core_start); end
      repeat (10) tick();
      n_cmp++; if ({bus.core_data, bus.tx_valid, bus.rx_ready} !== {PT, 2'b00}) begin
         n_err++; $display("FAIL enc_wait_hold: got %h %b %b", bus.core_data, bus.tx_valid, bus.rx_ready); end
      bus.core_done = 1'b1; bus.core_result = CT128;
      tick();
      bus.core_done = 1'b0; bus.core_result = '0;
      n_cmp++; if (bus.tx_valid !== 1'b0) begin n_err++; $display("FAIL enc_push_early: got %b want 0", bus.tx_valid); end
      tick();
      n_cmp++; if (bus.tx_valid !== 1'b1) begin n_err++; $display("FAIL enc_tx_valid: got %b want 1", bus.tx_valid); end
      n_cmp++; if ({bus.tx_status, bus.tx_data} !== {2'b00, CT128}) begin
         n_err++; $display("FAIL enc_tx: got %b %h want 00 %h", bus.tx_status, bus.tx_data, CT128); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL enc_busy_end: got %b want 0", bus.busy); end
      bus.tx_ready = 1'b1;
      tick();
      bus.tx_ready = 1'b0;
      n_cmp++; if (bus.tx_valid !== 1'b0) begin n_err++; $display("FAIL enc_pop: got %b want 0", bus.tx_valid); end
   endtask

   task automatic test_dec256();
      bus.rx_frame = mk(CT256, 8'hA0, KEY256);
      bus.rx_valid = 1'b1;
      tick();
      bus.rx_valid = 1'b0;
      n_cmp++; if ({bus.core_start, bus.core_mode, bus.core_klen} !== 4'b1110) begin
         n_err++; $display("FAIL dec_ctrl: got %b want 1110", {bus.core_start, bus.core_mode, bus.core_klen}); end
      n_cmp++; if ({bus.core_data, bus.core_key} !== {CT256, KEY256}) begin n_err++; $display("FAIL dec_operands: got %h", bus.core_data); end
      tick();
      tick();
      bus.core_done = 1'b1; bus.core_result = PT;
      tick();
      bus.core_done = 1'b0;
      tick();
      n_cmp++; if ({bus.tx_valid, bus.tx_status, bus.tx_data} !== {1'b1, 2'b00, PT}) begin
         n_err++; $display("FAIL dec_tx: got %b %b %h want 1 00 %h", bus.tx_valid, bus.tx_status, bus.tx_data, PT); end
      bus.tx_ready = 1'b1;
      tick();
      bus.tx_ready = 1'b0;
   endtask

   task automatic test_invalid();
      bus.rx_frame = mk(PT, 8'h11, KEY128);
      bus.rx_valid = 1'b1;
      tick();
      bus.rx_valid = 1'b0;
      n_cmp++; if ({bus.core_start, bus.busy, bus.tx_valid} !== 3'b010) begin
         n_err++; $display("FAIL inv_n1: got %b want 010", {bus.core_start, bus.busy, bus.tx_valid}); end
      tick();
      n_cmp++; if ({bus.tx_valid, bus.tx_status, bus.tx_data} !== {1'b1, 2'b01, 128'h0}) begin
         n_err++; $display("FAIL inv_tx: got %b %b %h want 1 01 0", bus.tx_valid, bus.tx_status, bus.tx_data); end
      n_cmp++; if (bus.err_count !== 8'd1) begin n_err++; $display("FAIL inv_err: got %0d want 1", bus.err_count); end
      bus.tx_ready = 1'b1;
      tick();
      bus.tx_ready = 1'b0;
   endtask

   task automatic test_timeout();
      int lat;
      lat = -1;
      bus2.rx_frame = mk(PT, 8'h10, KEY128);
      bus2.rx_valid = 1'b1;
      tick();
      bus2.rx_valid = 1'b0;
      n_cmp++; if (bus2.core_start !== 1'b1) begin n_err++; $display("FAIL to_start: got %b want 1", bus2.core_start); end
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (bus2.tx_valid === 1'b1) begin lat = k; break; end
      end
      // PUSH sits 9 cycles after START, so the entry is visible one cycle later
      n_cmp++; if (lat !== 10) begin n_err++; $display("FAIL to_latency: got %0d want 10", lat); end
      n_cmp++; if ({bus2.tx_status, bus2.tx_data} !== {2'b10, 128'h0}) begin
         n_err++; $display("FAIL to_tx: got %b %h want 10 0", bus2.tx_status, bus2.tx_data); end
      n_cmp++; if ({bus2.busy, bus2.err_count} !== {1'b0, 8'd1}) begin
         n_err++; $display("FAIL to_busy_err: got %b %0d want 0 1", bus2.busy, bus2.err_count); end
      bus2.tx_ready = 1'b1;
      tick();
      bus2.tx_ready = 1'b0;
   endtask

   task automatic txn(input logic [127:0] d, input logic [127:0] res);
      bus.rx_frame = mk(d, 8'h10, KEY128);
      bus.rx_valid = 1'b1;
      for (int i = 0; i < 50 && bus.rx_ready !== 1'b1; i++) tick();
      n_cmp++; if (bus.rx_ready !== 1'b1) begin n_err++; $display("FAIL txn_ready: got %b want 1", bus.rx_ready); end
      tick();
      bus.rx_valid = 1'b0;
      tick();
      bus.core_done = 1'b1; bus.core_result = res;
      tick();
      bus.core_done = 1'b0;
      tick();
   endtask

   task automatic test_fifo_full();
      logic [127:0] res [5];
      for (int i = 0; i < 5; i++) res[i] = 128'hC0DE_0000 + 128'(i);
      bus.tx_ready = 1'b0;
      for (int i = 0; i < 4; i++) txn(128'(i), res[i]);
      n_cmp++; if ({bus.rx_ready, bus.tx_valid} !== 2'b01) begin
         n_err++; $display("FAIL full_rdy: got %b want 01", {bus.rx_ready, bus.tx_valid}); end
      bus.rx_frame = mk(128'h4, 8'h10, KEY128);
      bus.rx_valid = 1'b1;
      repeat (3) tick();
      n_cmp++; if ({bus.rx_ready, bus.busy} !== 2'b00) begin
         n_err++; $display("FAIL full_blocked: got %b want 00", {bus.rx_ready, bus.busy}); end
      n_cmp++; if (bus.tx_data !== res[0]) begin n_err++; $display("FAIL full_hold: got %h want %h", bus.tx_data, res[0]); end
      bus.tx_ready = 1'b1;
      tick();
      bus.tx_ready = 1'b0;
      n_cmp++; if ({bus.rx_ready, bus.tx_data} !== {1'b1, res[1]}) begin
         n_err++; $display("FAIL full_pop1: got %b %h want 1 %h", bus.rx_ready, bus.tx_data, res[1]); end
      tick();
      bus.rx_valid = 1'b0;
      n_cmp++; if (bus.core_start !== 1'b1) begin n_err++; $display("FAIL full_fifth_start: got %b want 1", bus.core_start); end
      tick();
      bus.core_done = 1'b1; bus.core_result = res[4];
      tick();
      bus.core_done = 1'b0;
      bus.tx_ready = 1'b1;
      tick();
      bus.tx_ready = 1'b0;
      n_cmp++; if ({bus.rx_ready, bus.tx_valid, bus.tx_data} !== {2'b11, res[2]}) begin
         n_err++; $display("FAIL full_pushpop: got %b %b %h want 1 1 %h", bus.rx_ready, bus.tx_valid, bus.tx_data, res[2]); end
      for (int j = 2; j < 5; j++) begin
         n_cmp++; if ({bus.tx_status, bus.tx_data} !== {2'b00, res[j]}) begin
            n_err++; $display("FAIL full_order%0d: got %h want %h", j, bus.tx_data, res[j]); end
         bus.tx_ready = 1'b1;
         tick();
         bus.tx_ready = 1'b0;
      end
      n_cmp++; if (bus.tx_valid !== 1'b0) begin n_err++; $display("FAIL full_drained: got %b want 0", bus.tx_valid); end
   endtask

   task automatic test_err_saturate();
      bus.rx_frame = mk(PT, 8'h05, KEY128);
      bus.rx_valid = 1'b1;
      bus.tx_ready = 1'b1;
      repeat (800) tick();
      bus.rx_valid = 1'b0;
      repeat (4) tick();
      bus.tx_ready = 1'b0;
      n_cmp++; if ({bus.err_count, bus.tx_valid} !== {8'd255, 1'b0}) begin
         n_err++; $display("FAIL err_sat: got %0d %b want 255 0", bus.err_count, bus.tx_valid); end
   endtask

   task automatic test_reset_mid();
      bus.rx_frame = mk(PT, 8'h11, KEY128);
      bus.rx_valid = 1'b1;
      tick();
      bus.rx_valid = 1'b0;
      tick();
      tick();
      n_cmp++; if (bus.tx_valid !== 1'b1) begin n_err++; $display("FAIL rm_queued: got %b want 1", bus.tx_valid); end
      bus.rx_frame = mk(PT, 8'h10, KEY128);
      bus.rx_valid = 1'b1;
      tick();
      bus.rx_valid = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      bus.core_done = 1'b1; bus.core_result = CT128;
      tick();
      bus.core_done = 1'b0;
      tick();
      tick();
      n_cmp++; if ({bus.tx_valid, bus.busy, bus.rx_ready, bus.core_start} !== 4'b0010) begin
         n_err++; $display("FAIL rm_state: got %b want 0010", {bus.tx_valid, bus.busy, bus.rx_ready, bus.core_start}); end
      n_cmp++; if (bus.err_count !== 8'd0) begin n_err++; $display("FAIL rm_err: got %0d want 0", bus.err_count); end
   endtask

   initial begin
      reset = 1'b1;
      bus.rx_valid = 1'b0; bus.rx_frame = '0; bus.core_done = 1'b0;
      bus.core_result = '0; bus.tx_ready = 1'b0;
      bus2.rx_valid = 1'b0; bus2.rx_frame = '0; bus2.core_done = 1'b0;
      bus2.core_result = '0; bus2.tx_ready = 1'b0;
      test_reset();
      test_enc128();
      test_dec256();
      test_invalid();
      test_timeout();
      test_fifo_full();
      test_err_saturate();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
